hazard_scoreboard: RTL

//  Parametrised hazard/forwarding controller for the 5-stage MIPS pipeline.

---
 rtl/hazard_scoreboard_pkg.sv | 30 +++
 rtl/hazard_scoreboard_ll_scoreboard.sv | 69 ++++++
 rtl/hazard_scoreboard.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared constants and forward-select helpers for the hazard unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

  localparam int REG_HI = 32;
  localparam int REG_LO = 33;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  // M-stage result is younger than W, so it takes priority.
  function automatic logic [1:0] fwdSel(input logic srcNz, input logic hitM, input logic hitW);
    logic [1:0] sel;
    sel = FWD_RF;
    if (srcNz && hitM)      sel = FWD_M;
    else if (srcNz && hitW) sel = FWD_W;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_ll_scoreboard.sv
// ============================================================================
// Module : ll_scoreboard
// Brief  : Busy bits and outstanding count for long-latency register writes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ll_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 6,
  parameter int NUM_REGS = 34,
  parameter int LL_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              llIssueD,
  input  logic [REG_AW-1:0] llDestD,
  input  logic              issueOk,
  input  logic              llDone,
  input  logic [REG_AW-1:0] llDoneReg,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  output logic              sbstall
);

  localparam int CW = (LL_DEPTH < 1) ? 1 : $clog2(LL_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_MAX = CW'(LL_DEPTH);

  logic [NUM_REGS-1:0] r_busy;
  logic [CW-1:0]       r_count;
  logic                w_issue;
  logic                w_retire;
  logic                w_full;

  // Out-of-range and zero indices always read as not busy.
  function automatic logic busyAt(input logic [REG_AW-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == REG_AW'(i)) hit = hit | r_busy[i];
    end
    return hit;
  endfunction

  assign w_full   = (r_count == DEPTH_MAX);
  assign w_issue  = llIssueD & issueOk & (llDestD != '0);
  assign w_retire = llDone & busyAt(llDoneReg);
  assign sbstall  = busyAt(RsD) | busyAt(RtD) | (llIssueD & (busyAt(llDestD) | w_full));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      // Set after clear so a same-index issue/retire leaves the bit busy.
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_retire && llDoneReg == REG_AW'(i)) r_busy[i] <= 1'b0;
        if (w_issue && llDestD == REG_AW'(i))    r_busy[i] <= 1'b1;
      end
      r_busy[0] <= 1'b0;
      if (w_issue && !w_retire)      r_count <= r_count + CW'(1);
      else if (!w_issue && w_retire) r_count <= r_count - CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module : hazard_scoreboard
// Brief  : Stall/flush/forward controller with long-latency scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 6,
  parameter int NUM_REGS = 34,
  parameter int LL_DEPTH = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              BranchD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              MemWriteM,
  input  logic              MemReady,
  input  logic              llIssueD,
  input  logic [REG_AW-1:0] llDestD,
  input  logic              llDone,
  input  logic [REG_AW-1:0] llDoneReg,
  input  logic              clrBufferD,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic [CNT_W-1:0]  stallCycles
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_memStall;
  logic             w_lwStall;
  logic             w_branchStall;
  logic             w_sbStall;
  logic             w_dStall;
  logic             w_issueOk;
  logic             r_flushPend;
  logic [CNT_W-1:0] r_stallCycles;

  function automatic logic destHits(input logic [REG_AW-1:0] dest,
                                    input logic [REG_AW-1:0] a,
                                    input logic [REG_AW-1:0] b);
    return (dest != '0) && ((dest == a) || (dest == b));
  endfunction

  assign w_memStall    = (MemWriteM | MemtoRegM) & ~MemReady;
  assign w_lwStall     = MemtoRegE & destHits(WriteRegE, RsD, RtD);
  assign w_branchStall = BranchD & ((RegWriteE & destHits(WriteRegE, RsD, RtD)) |
                                    (MemtoRegM & destHits(WriteRegM, RsD, RtD)));
  assign w_dStall      = w_lwStall | w_branchStall | w_sbStall;
  assign w_issueOk     = ~StallD & ~FlushD;

  ll_scoreboard #(
    .REG_AW   (REG_AW),
    .NUM_REGS (NUM_REGS),
    .LL_DEPTH (LL_DEPTH)
  ) u_llScoreboard (
    .clk       (clk),
    .reset     (reset),
    .llIssueD  (llIssueD),
    .llDestD   (llDestD),
    .issueOk   (w_issueOk),
    .llDone    (llDone),
    .llDoneReg (llDoneReg),
    .RsD       (RsD),
    .RtD       (RtD),
    .sbstall   (w_sbStall)
  );

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b0;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    if (!reset) begin
      StallF    = w_dStall | w_memStall;
      StallD    = w_dStall | w_memStall;
      StallE    = w_memStall;
      StallM    = w_memStall;
      FlushW    = w_memStall;
      FlushE    = w_dStall & ~w_memStall;
      // A jump seen during a memory stall is deferred until the stall ends.
      FlushD    = (clrBufferD | r_flushPend) & ~w_memStall;
      ForwardAD = (RsD != '0) & (RsD == WriteRegM) & RegWriteM;
      ForwardBD = (RtD != '0) & (RtD == WriteRegM) & RegWriteM;
      ForwardAE = fwdSel(RsE != '0, RegWriteM && (RsE == WriteRegM), RegWriteW && (RsE == WriteRegW));
      ForwardBE = fwdSel(RtE != '0, RegWriteM && (RtE == WriteRegM), RegWriteW && (RtE == WriteRegW));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flushPend   <= 1'b0;
      r_stallCycles <= '0;
    end else begin
      if (FlushD)                       r_flushPend <= 1'b0;
      else if (clrBufferD & w_memStall) r_flushPend <= 1'b1;
      if (StallF && (r_stallCycles != CNT_MAX)) r_stallCycles <= r_stallCycles + CNT_W'(1);
    end
  end

  assign stallCycles = r_stallCycles;

endmodule

`default_nettype wire
